// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral address bridge.
//   - FSM state encoding used by sys_bridge_v2
//   - bus widths
//   - default address windows for the DM, timer 0, timer 1 and
//     interrupt-generator slaves
package bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] DM_BASE   = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DM_LIMIT  = 32'h0000_2fff;
  localparam logic [ADDR_W-1:0] T0_BASE   = 32'h0000_7f00;
  localparam logic [ADDR_W-1:0] T0_LIMIT  = 32'h0000_7f0b;
  localparam logic [ADDR_W-1:0] T1_BASE   = 32'h0000_7f10;
  localparam logic [ADDR_W-1:0] T1_LIMIT  = 32'h0000_7f1b;
  localparam logic [ADDR_W-1:0] INT_BASE  = 32'h0000_7f20;
  localparam logic [ADDR_W-1:0] INT_LIMIT = 32'h0000_7f23;

endpackage

// File: rtl/addr_decoder.sv
// Combinational address decoder.
// Compares addr against N_SLV inclusive [base, limit] windows (unsigned).
// Overlapping windows resolve to the lowest slot index.
// Ports:
//   addr  in   byte address
//   hit   out  one-hot hit vector (all zero on a miss)
//   slot  out  index of the winning slot (0 on a miss)
//   miss  out  no window contains addr
module addr_decoder
  import bridge_pkg::*;
#(
  parameter int                     N_SLV     = 4,
  parameter logic [32*N_SLV-1:0]    SLV_BASE  = {INT_BASE, T1_BASE, T0_BASE, DM_BASE},
  parameter logic [32*N_SLV-1:0]    SLV_LIMIT = {INT_LIMIT, T1_LIMIT, T0_LIMIT, DM_LIMIT},
  localparam int                    SLOT_W    = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_SLV-1:0]  hit,
  output logic [SLOT_W-1:0] slot,
  output logic              miss
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a combinational signal unassigned (which would infer a latch).
    hit  = '0;
    slot = '0;
    miss = 1'b1;
    // Scan from the highest slot down so a lower-index hit overwrites a
    // higher one: the lowest index wins on overlap.
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if ((addr >= SLV_BASE[32*k +: 32]) && (addr <= SLV_LIMIT[32*k +: 32])) begin
        hit    = '0;
        hit[k] = 1'b1;
        slot   = SLOT_W'(k);
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sys_bridge_v2.sv
// Parametrised CPU-to-peripheral address bridge.
// Accepts one request from the MEM-stage master, decodes it against N_SLV
// windows, holds the selected slave for its wait states and completes with
// a one-cycle pr_ready pulse. Unmapped accesses and writes to read-only
// slots complete with pr_err and are recorded in a sticky fault register.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   pr_req/we/addr/wdata    master request (held until pr_ready)
//   pr_rdata/ready/err      master completion
//   dev_addr/wdata          latched address/data broadcast to slaves
//   dev_sel                 one-hot slave select, active during WAIT
//   dev_we                  per-slave byte enables, completion cycle only
//   dev_rdata               per-slave read data
//   fault_clr               clears fault_valid
//   fault_valid/addr        sticky fault flag and last faulting address
//   err_cnt                 saturating error count
module sys_bridge_v2
  import bridge_pkg::*;
#(
  parameter int                     N_SLV     = 4,
  parameter logic [32*N_SLV-1:0]    SLV_BASE  = {INT_BASE, T1_BASE, T0_BASE, DM_BASE},
  parameter logic [32*N_SLV-1:0]    SLV_LIMIT = {INT_LIMIT, T1_LIMIT, T0_LIMIT, DM_LIMIT},
  parameter logic [4*N_SLV-1:0]     SLV_WAIT  = {4'd0, 4'd1, 4'd1, 4'd0},
  parameter logic [N_SLV-1:0]       SLV_RO    = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pr_req,
  input  logic [BE_W-1:0]         pr_we,
  input  logic [ADDR_W-1:0]       pr_addr,
  input  logic [DATA_W-1:0]       pr_wdata,
  output logic [DATA_W-1:0]       pr_rdata,
  output logic                    pr_ready,
  output logic                    pr_err,
  output logic [ADDR_W-1:0]       dev_addr,
  output logic [DATA_W-1:0]       dev_wdata,
  output logic [N_SLV-1:0]        dev_sel,
  output logic [BE_W*N_SLV-1:0]   dev_we,
  input  logic [DATA_W*N_SLV-1:0] dev_rdata,
  input  logic                    fault_clr,
  output logic                    fault_valid,
  output logic [ADDR_W-1:0]       fault_addr,
  output logic [7:0]              err_cnt
);

  localparam int SLOT_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [BE_W-1:0]     lat_we;
  logic [SLOT_W-1:0]   lat_slot;
  logic [WAIT_W-1:0]   cnt;

  logic [N_SLV-1:0]    hit;
  logic [SLOT_W-1:0]   slot;
  logic                miss;

  logic [WAIT_W-1:0]   wait_sel;
  logic                ro_hit;
  logic                accept;
  logic                bad_access;

  logic [N_SLV-1:0]      sel_onehot;
  logic [DATA_W-1:0]     rdata_mux;
  logic [BE_W*N_SLV-1:0] we_spread;

  addr_decoder #(
    .N_SLV     (N_SLV),
    .SLV_BASE  (SLV_BASE),
    .SLV_LIMIT (SLV_LIMIT)
  ) u_dec (
    .addr (pr_addr),
    .hit  (hit),
    .slot (slot),
    .miss (miss)
  );

  // Per-slot attributes of the incoming request, selected by the hit vector.
  always_comb begin
    wait_sel = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (hit[k]) wait_sel = SLV_WAIT[4*k +: 4];
    end
  end

  assign ro_hit     = |(hit & SLV_RO);
  assign accept     = (state == IDLE) && pr_req;
  assign bad_access = miss || ((pr_we != '0) && ro_hit);

  // Select/steer signals for the latched slot.
  always_comb begin
    sel_onehot = '0;
    rdata_mux  = '0;
    we_spread  = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (lat_slot == SLOT_W'(k)) begin
        sel_onehot[k]          = 1'b1;
        rdata_mux              = dev_rdata[32*k +: 32];
        we_spread[4*k +: 4]    = lat_we;
      end
    end
  end

  // FSM next state and bus outputs.
  always_comb begin
    state_n  = state;
    pr_ready = 1'b0;
    pr_err   = 1'b0;
    pr_rdata = '0;
    dev_sel  = '0;
    dev_we   = '0;
    unique case (state)
      IDLE: begin
        if (pr_req) state_n = bad_access ? ERR : WAIT;
      end
      WAIT: begin
        dev_sel = sel_onehot;
        if (cnt == '0) begin
          pr_ready = 1'b1;
          pr_rdata = rdata_mux;
          dev_we   = we_spread;
          state_n  = IDLE;
        end
      end
      ERR: begin
        pr_ready = 1'b1;
        pr_err   = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop in
  // the block samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= '0;
      lat_slot  <= '0;
      cnt       <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        lat_addr  <= pr_addr;
        lat_wdata <= pr_wdata;
        lat_we    <= pr_we;
        lat_slot  <= slot;
        cnt       <= wait_sel;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Sticky fault register; a fault being recorded overrides a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      err_cnt     <= '0;
    end else if (state == ERR) begin
      fault_valid <= 1'b1;
      fault_addr  <= lat_addr;
      if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
    end else if (fault_clr) begin
      fault_valid <= 1'b0;
    end
  end

  assign dev_addr  = lat_addr;
  assign dev_wdata = lat_wdata;

endmodule

// File: doc/sys_bridge_v2.md
Name: sys_bridge_v2

Overview:
Parametrised successor to the CPU-to-peripheral address bridge. Decodes a processor data-bus request against N_SLV address windows (DM, timers, interrupt generator, future devices) and routes it to the selected slave. Inserts per-slave wait states through a registered request/ready handshake. Detects unmapped accesses and writes to read-only slaves, and latches them in a sticky fault register. Sits between the MEM-stage bus master and all memory-mapped slaves.

Parameters:
N_SLV, 4, number of slave windows (1..8)
SLV_BASE, {32'h7f20,32'h7f10,32'h7f00,32'h0}, flat 32*N_SLV; inclusive base address per slot
SLV_LIMIT, {32'h7f23,32'h7f1b,32'h7f0b,32'h2fff}, flat 32*N_SLV; inclusive limit address per slot
SLV_WAIT, {4'd0,4'd1,4'd1,4'd0}, flat 4*N_SLV; wait states per slot (0..15)
SLV_RO, 4'b0000, bitmask; 1 = slot is read-only

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pr_req  in  1  request valid; held by master until pr_ready
pr_we  in  4  byte write enables; 0 = read
pr_addr  in  32  byte address
pr_wdata  in  32  write data
pr_rdata  out  32  read data; valid only while pr_ready
pr_ready  out  1  one-cycle completion pulse
pr_err  out  1  completion carries an error; qualified by pr_ready
dev_addr  out  32  latched address to all slaves
dev_wdata  out  32  latched write data to all slaves
dev_sel  out  N_SLV  one-hot slave select
dev_we  out  4*N_SLV  per-slave byte enables; slot k occupies bits [4k+3:4k]
dev_rdata  in  32*N_SLV  per-slave read data; slot k occupies bits [32k+31:32k]
fault_clr  in  1  clears fault_valid
fault_valid  out  1  sticky error flag
fault_addr  out  32  address of the most recent faulting access
err_cnt  out  8  saturating error counter

Behaviour:
- Reset: asynchronous on reset_n low. FSM goes to IDLE. All outputs are 0: pr_ready, pr_err, pr_rdata, dev_sel, dev_we, dev_addr, dev_wdata, fault_valid, fault_addr, err_cnt. Latched request registers are cleared.
- Decode: slot k hits when SLV_BASE[k] <= addr <= SLV_LIMIT[k], both comparisons unsigned 32-bit. When windows overlap, the lowest index wins.
- FSM states: IDLE, WAIT, ERR.
- IDLE, pr_req=1 at cycle T: latch addr, wdata, we and the hit slot.
  - Miss, or pr_we!=0 to an SLV_RO slot: go to ERR.
  - Otherwise: load cnt=SLV_WAIT[slot] and go to WAIT.
- WAIT: dev_sel[slot]=1 and dev_addr/dev_wdata driven from the latches for every WAIT cycle.
  - cnt!=0: decrement cnt.
  - cnt==0: drive pr_ready=1 and pr_rdata=dev_rdata[slot] combinationally. Drive dev_we[slot]=latched we for this single cycle only. Next state is IDLE.
- ERR, lasting one cycle: pr_ready=1, pr_err=1, pr_rdata=0. dev_sel and all dev_we stay 0. Next state is IDLE.
- Latency: completion at T+1+SLV_WAIT[slot]; errors complete at T+1. The earliest next accept is the cycle after completion, so peak throughput is one access per 2 cycles.
- pr_req/pr_addr changes after T are ignored until completion; the latched request always finishes.
- In IDLE, dev_sel=0, dev_we=0, pr_ready=0. dev_addr holds its last latched value.
- Device writes occur only in the completion cycle. No write reaches a slave for an erroring access.
- Fault register:
  - On ERR completion: fault_valid<=1, fault_addr<=latched addr, err_cnt<=err_cnt+1, saturating at 8'hff.
  - fault_clr clears fault_valid only; fault_addr and err_cnt are kept.
  - fault_clr in the same cycle as ERR completion: set wins.
- Reset mid-transaction: the access is abandoned with no dev_we pulse, and the bus returns to IDLE.

Decomposition:
- Shared package bridge_pkg holds:
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, ERR=2'd2);
  - ADDR_W=32, DATA_W=32, BE_W=4;
  - default DM/T0/T1/INT base and limit constants.
- One natural sub-module, addr_decoder: purely combinational, with parameters N_SLV/SLV_BASE/SLV_LIMIT. Its inputs are addr; its outputs are a one-hot hit vector, a slot index and a miss flag, with lowest-index priority.
- The FSM, wait counter and fault logic stay in sys_bridge_v2.

Test Plan:
- Default params, read 32'h0000_0100 with dev_rdata slot0=32'hdeadbeef, req at T -> pr_ready at T+1, pr_rdata=32'hdeadbeef, pr_err=0, dev_sel=4'b0001, dev_we=0.
- Write 32'h7f04 with pr_we=4'hf, wdata=32'h5 -> dev_sel[1]=1 at T+1 and T+2. dev_we[7:4]=4'hf only at T+2, which is also the pr_ready cycle. All other dev_we bits stay 0.
- Boundary decode: addr 32'h2fff -> slot0; addr 32'h3000 -> ERR at T+1 with pr_rdata=0, fault_valid=1, fault_addr=32'h3000, err_cnt=1. addr 32'h7f1b -> slot2; addr 32'h7f1c -> ERR.
- SLV_RO=4'b1000, write 32'h7f20 -> pr_err=1, no dev_we pulse, fault_valid=1. A read of 32'h7f20 -> normal completion at T+1.
- fault_clr asserted in the same cycle as an ERR completion -> fault_valid stays 1. 256 consecutive errors -> err_cnt=8'hff, saturated.
- reset_n pulsed low during WAIT of a slot1 write -> all outputs 0 immediately, no dev_we pulse ever issued, next pr_req is accepted from IDLE.
